ip_codma_write_machine: RTL and testbench

- Write-side stage of the codma engine, directly downstream of the read machine.
- Captures the 8x32-bit data register filled by the read machine, requests the memory bus and emits it as a burst of 64-bit write beats.
- Reports done or error status to the top-level DMA state machine.
- Owns a private copy of the data, so the read machine can start its next fetch as soon as capture occurs.

---
 rtl/ip_codma_pkg.sv | 29 ++
 rtl/ip_codma_write_machine.sv | 164 ++++++++++++++++
 tb/tb_ip_codma_write_machine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ip_codma_pkg.sv
// ip_codma_pkg
//   Shared types and helpers for the codma engine.
//   - write_state_t : write machine state encoding
//   - SIZE_*        : bus size codes understood by the write machine
//   - size_to_beats : number of 64-bit beats for a size code (0 = unsupported)
package ip_codma_pkg;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_ASK     = 3'd1,
    WR_GRANTED = 3'd2,
    WR_DONE    = 3'd3,
    WR_BADSIZE = 3'd4
  } write_state_t;

  localparam logic [3:0] SIZE_8W = 4'd9;
  localparam logic [3:0] SIZE_6W = 4'd8;
  localparam logic [3:0] SIZE_2W = 4'd3;

  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    case (size)
      SIZE_8W: size_to_beats = 3'd4;
      SIZE_6W: size_to_beats = 3'd3;
      SIZE_2W: size_to_beats = 3'd1;
      default: size_to_beats = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_write_machine.sv
// ip_codma_write_machine
//   Write-side stage of the codma engine. On need_write_i (in WR_IDLE) it takes
//   a private copy of the read machine's data register, address and size code,
//   requests the bus and sends the buffer as a burst of 64-bit beats
//   (two 32-bit words per beat, low word on [31:0]).
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   need_write_i              start request (sampled in WR_IDLE only)
//   wr_addr_i, wr_size_i      burst base address and size code
//   data_reg_i                WORDS x 32-bit data from the read machine
//   stop_i                    synchronous abort, back to WR_IDLE
//   dma_error_i, bus_error_i  error abort, back to WR_IDLE with error flag set
//   bus_req_o / bus_grant_i   bus arbitration
//   bus_addr_o, bus_size_o    captured address / size code
//   bus_write_valid_o/_data_o write beat, accepted when bus_write_ready_i high
//   busy_o                    not in WR_IDLE
//   write_done_o              one-cycle completion pulse
//   wr_state_error_o          sticky error flag
//   wr_state_o                current state
module ip_codma_write_machine
  import ip_codma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 8,
  parameter int BEAT_W = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    need_write_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [3:0]              wr_size_i,
  input  logic [WORDS-1:0][31:0]  data_reg_i,
  input  logic                    stop_i,
  input  logic                    dma_error_i,
  output logic                    bus_req_o,
  input  logic                    bus_grant_i,
  output logic [ADDR_W-1:0]       bus_addr_o,
  output logic [3:0]              bus_size_o,
  output logic                    bus_write_valid_o,
  output logic [BEAT_W-1:0]       bus_write_data_o,
  input  logic                    bus_write_ready_i,
  input  logic                    bus_error_i,
  output logic                    busy_o,
  output logic                    write_done_o,
  output logic                    wr_state_error_o,
  output write_state_t            wr_state_o
);

  // Beat index selects a word pair, so it needs one bit less than a word index.
  localparam int CNT_W = $clog2(WORDS) - 1;

  write_state_t              state_q, state_d;
  logic [WORDS-1:0][31:0]    buf_q, buf_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [3:0]                size_q, size_d;
  logic [CNT_W-1:0]          beat_q, beat_d;
  logic                      error_q, error_d;

  logic       abort_err;
  logic       accept;
  logic       start;
  logic       last_beat;
  logic [2:0] beats_cur;

  assign abort_err = bus_error_i | dma_error_i;
  assign accept    = (state_q == WR_GRANTED) & bus_write_ready_i;
  // An abort in the request cycle wins: nothing is captured.
  assign start     = (state_q == WR_IDLE) & need_write_i & ~stop_i & ~abort_err;
  assign beats_cur = size_to_beats(size_q);
  assign last_beat = (beat_q == CNT_W'(beats_cur - 3'd1));

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= WR_IDLE;
      buf_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      beat_q  <= beat_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    size_d  = size_q;
    beat_d  = beat_q;
    error_d = error_q;

    case (state_q)
      WR_IDLE: begin
        if (start) begin
          buf_d   = data_reg_i;
          addr_d  = wr_addr_i;
          size_d  = wr_size_i;
          beat_d  = '0;
          if (size_to_beats(wr_size_i) != 3'd0) begin
            state_d = WR_ASK;
            error_d = 1'b0;
          end else begin
            // Flag is raised on entry so it is visible during WR_BADSIZE.
            state_d = WR_BADSIZE;
            error_d = 1'b1;
          end
        end
      end
      WR_ASK: begin
        if (bus_grant_i) state_d = WR_GRANTED;
      end
      WR_GRANTED: begin
        if (accept) begin
          // Counted even under stop: the slave has taken the beat.
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) state_d = WR_DONE;
        end
      end
      WR_DONE:    state_d = WR_IDLE;
      WR_BADSIZE: state_d = WR_IDLE;
      default:    state_d = WR_IDLE;
    endcase

    if (stop_i) state_d = WR_IDLE;
    if (abort_err) begin
      state_d = WR_IDLE;
      error_d = 1'b1;
    end
  end

  // Output logic: decoded from registered state only
  always_comb begin
    bus_req_o         = 1'b0;
    bus_write_valid_o = 1'b0;
    bus_write_data_o  = '0;
    write_done_o      = 1'b0;
    case (state_q)
      WR_ASK: bus_req_o = 1'b1;
      WR_GRANTED: begin
        bus_req_o         = 1'b1;
        bus_write_valid_o = 1'b1;
        bus_write_data_o  = BEAT_W'({buf_q[{beat_q, 1'b1}], buf_q[{beat_q, 1'b0}]});
      end
      WR_DONE: write_done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus_addr_o       = addr_q;
  assign bus_size_o       = size_q;
  assign busy_o           = (state_q != WR_IDLE);
  assign wr_state_error_o = error_q;
  assign wr_state_o       = state_q;

endmodule

// File: tb/tb_ip_codma_write_machine.sv
// tb_ip_codma_write_machine
//   Directed bench for ip_codma_write_machine. Inputs change 1 ns after the
//   rising edge; outputs are sampled at that same point, well clear of the edge.
module tb_ip_codma_write_machine;
  import ip_codma_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                need_write = 1'b0;
  logic [31:0]         wr_addr = '0;
  logic [3:0]          wr_size = '0;
  logic [7:0][31:0]    data_reg = '0;
  logic                stop = 1'b0;
  logic                dma_error = 1'b0;
  logic                bus_req;
  logic                bus_grant = 1'b0;
  logic [31:0]         bus_addr;
  logic [3:0]          bus_size;
  logic                bus_write_valid;
  logic [63:0]         bus_write_data;
  logic                bus_write_ready = 1'b0;
  logic                bus_error = 1'b0;
  logic                busy;
  logic                write_done;
  logic                wr_state_error;
  write_state_t        wr_state;

  int checks = 0;
  int errors = 0;

  ip_codma_write_machine dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .need_write_i      (need_write),
    .wr_addr_i         (wr_addr),
    .wr_size_i         (wr_size),
    .data_reg_i        (data_reg),
    .stop_i            (stop),
    .dma_error_i       (dma_error),
    .bus_req_o         (bus_req),
    .bus_grant_i       (bus_grant),
    .bus_addr_o        (bus_addr),
    .bus_size_o        (bus_size),
    .bus_write_valid_o (bus_write_valid),
    .bus_write_data_o  (bus_write_data),
    .bus_write_ready_i (bus_write_ready),
    .bus_error_i       (bus_error),
    .busy_o            (busy),
    .write_done_o      (write_done),
    .wr_state_error_o  (wr_state_error),
    .wr_state_o        (wr_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) data_reg[i] = base + 32'(i);
  endtask

  // Status snapshot: state, req, valid, done, error
  task automatic chk_ctl(input string tag, input write_state_t st, input logic req,
                         input logic vld, input logic done, input logic err);
    chk({tag, ".state"}, 64'(wr_state), 64'(st));
    chk({tag, ".req"},   64'(bus_req), 64'(req));
    chk({tag, ".valid"}, 64'(bus_write_valid), 64'(vld));
    chk({tag, ".done"},  64'(write_done), 64'(done));
    chk({tag, ".err"},   64'(wr_state_error), 64'(err));
  endtask

  logic [63:0] beats9 [4] = '{64'h00000001_00000000, 64'h00000003_00000002,
                              64'h00000005_00000004, 64'h00000007_00000006};
  logic        rdy_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] exp8    [5] = '{64'h00000011_00000010, 64'h00000013_00000012,
                              64'h00000013_00000012, 64'h00000013_00000012,
                              64'h00000015_00000014};

  initial begin
    // Reset state
    #12;
    chk_ctl("rst", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.data", bus_write_data, 64'h0);
    chk("rst.addr", 64'(bus_addr), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);
    reset_n = 1'b1;
    step();

    // 1: size 9, grant/ready high -> ASK + 4 beats + DONE
    fill(32'h0);
    wr_addr = 32'h1000; wr_size = SIZE_8W; need_write = 1'b1;
    bus_grant = 1'b1; bus_write_ready = 1'b1;
    step(); need_write = 1'b0;
    chk_ctl("t1.ask", WR_ASK, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1.addr", 64'(bus_addr), 64'h1000);
    chk("t1.size", 64'(bus_size), 64'd9);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ctl($sformatf("t1.b%0d", i), WR_GRANTED, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t1.d%0d", i), bus_write_data, beats9[i]);
    end
    step();
    chk_ctl("t1.done", WR_DONE, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_ctl("t1.idle", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: size 8 with ready pattern 1,0,0,1,1
    fill(32'h10);
    wr_size = SIZE_6W; need_write = 1'b1; bus_write_ready = 1'b0;
    step(); need_write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      bus_write_ready = rdy_pat[c];
      chk($sformatf("t2.st%0d", c), 64'(wr_state), 64'(WR_GRANTED));
      chk($sformatf("t2.d%0d", c), bus_write_data, exp8[c]);
    end
    step(); bus_write_ready = 1'b1;
    chk_ctl("t2.done", WR_DONE, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: size 3, data and need_write wiggle mid-burst
    step();
    fill(32'h20);
    wr_size = SIZE_2W; need_write = 1'b1; bus_grant = 1'b0;
    step();
    fill(32'hDEAD0000);
    chk("t3.ask", 64'(wr_state), 64'(WR_ASK));
    step(); bus_grant = 1'b1;
    chk("t3.wait", 64'(wr_state), 64'(WR_ASK));
    step();
    chk("t3.data", bus_write_data, 64'h00000021_00000020);
    step(); need_write = 1'b0;
    chk_ctl("t3.done", WR_DONE, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("t3.one", 64'(busy), 64'h0);

    // 4: unsupported size 5
    wr_size = 4'd5; need_write = 1'b1;
    step(); need_write = 1'b0;
    chk_ctl("t4.bad", WR_BADSIZE, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_ctl("t4.idle", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    wr_size = SIZE_2W; need_write = 1'b1;
    step(); need_write = 1'b0;
    chk_ctl("t4.clr", WR_ASK, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step(); step();

    // 5: bus error on 2nd beat, then stop+error in ASK
    fill(32'h0);
    wr_size = SIZE_8W; need_write = 1'b1;
    step(); need_write = 1'b0;
    step();
    step(); bus_error = 1'b1;
    chk("t5.d1", bus_write_data, beats9[1]);
    step(); bus_error = 1'b0;
    chk_ctl("t5.abort", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_grant = 1'b0; need_write = 1'b1;
    step(); need_write = 1'b0;
    chk_ctl("t5.ask", WR_ASK, 1'b1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1; bus_error = 1'b1;
    step(); stop = 1'b0; bus_error = 1'b0;
    chk_ctl("t5.both", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: asynchronous reset mid-beat
    bus_grant = 1'b1; bus_write_ready = 1'b0; need_write = 1'b1;
    step(); need_write = 1'b0;
    step();
    chk("t6.pre", 64'(bus_write_valid), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk_ctl("t6.rst", WR_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.data", bus_write_data, 64'h0);
    chk("t6.addr", 64'(bus_addr), 64'h0);
    chk("t6.busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
